// File: rtl/fft_pkg.sv
// Shared types for the streaming radix-2 FFT stages: complex sample, twiddle
// pair, phase encoding and tw_addr width helper.
package fft_pkg;

  localparam int BIT_WIDTH      = 16;
  localparam int WORD_LENGTH_TW = 8;
  // Unity twiddle magnitude; sin/cos words are scaled by this value.
  localparam int TW_ONE         = 1 << (WORD_LENGTH_TW - 2);

  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] re;
    logic signed [BIT_WIDTH-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [WORD_LENGTH_TW-1:0] cos_w;
    logic signed [WORD_LENGTH_TW-1:0] sin_w;
  } twiddle_t;

  typedef enum logic {
    FILL = 1'b0,
    BFLY = 1'b1
  } phase_e;

  function automatic int addr_width(input int delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/radix2_dit_sdf_stage_if.sv
// Stream, twiddle-ROM and debug signals of one radix-2 DIT SDF stage.
// Optional rounding (RADIX2_DIT_ROUND_EN) does not change this bundle.
interface radix2_dit_sdf_stage_if #(
  parameter int bit_width      = 16,
  parameter int word_length_tw = 8,
  parameter int DELAY          = 8
);
  import fft_pkg::*;

  localparam int AW = fft_pkg::addr_width(DELAY);

  // Handshake: in_valid qualifies Re_in/Im_in/inverse for one cycle and the
  // stage always accepts (there is no ready). out_valid qualifies
  // Re_out/Im_out for exactly one cycle; the consumer cannot stall it.
  logic                             in_valid;
  logic signed [bit_width-1:0]      Re_in;
  logic signed [bit_width-1:0]      Im_in;
  logic                             inverse;
  logic [AW-1:0]                    tw_addr;
  logic signed [word_length_tw-1:0] sin_data;
  logic signed [word_length_tw-1:0] cos_data;
  logic                             out_valid;
  logic signed [bit_width-1:0]      Re_out;
  logic signed [bit_width-1:0]      Im_out;
  phase_e                           phase;

  modport master (
    output in_valid, Re_in, Im_in, inverse, sin_data, cos_data,
    input  tw_addr, out_valid, Re_out, Im_out, phase
  );

  modport slave (
    input  in_valid, Re_in, Im_in, inverse, sin_data, cos_data,
    output tw_addr, out_valid, Re_out, Im_out, phase
  );

endinterface

// File: rtl/sdf_delay_line.sv
// DEPTH-deep shift register holding packed complex samples; one enable both
// pushes din at the tail and advances the head. Contents are never reset.
module sdf_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] line_q [DEPTH];
  logic [WIDTH-1:0] line_d [DEPTH];

  always_comb begin
    line_d = line_q;
    if (en) begin
      line_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        line_d[i] = line_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/radix2_dit_sdf_stage.sv
// Radix-2 DIT single-path delay-feedback stage: twiddle applied to the lower
// input before add/subtract. Macro RADIX2_DIT_ROUND_EN enables round-half-up.
module radix2_dit_sdf_stage #(
  parameter int bit_width      = 16,
  parameter int word_length_tw = 8,
  parameter int DELAY          = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  radix2_dit_sdf_stage_if.slave  bus
);
  import fft_pkg::*;

  localparam int AW = fft_pkg::addr_width(DELAY);
  localparam int CW = $clog2(2 * DELAY);
  localparam int PW = bit_width + word_length_tw + 1;
  localparam int SH = word_length_tw - 2;
  localparam int DW = 2 * bit_width;

`ifdef RADIX2_DIT_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (word_length_tw - 3);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        primed_q, primed_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [bit_width-1:0] re_out_q, re_out_d;
  logic signed [bit_width-1:0] im_out_q, im_out_d;

  logic [DW-1:0]               line_din;
  logic [DW-1:0]               line_dout;
  phase_e                      phase;

  logic signed [PW-1:0]        a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]        cos_x, sin_x, s_x;
  logic signed [PW-1:0]        sum_re, sum_im, t_re, t_im;
  logic signed [bit_width-1:0] top_re, top_im, bot_re, bot_im;

  // 2*DELAY is a power of two, so the counter MSB marks the butterfly half.
  assign phase = (cnt_q >= CW'(DELAY)) ? BFLY : FILL;

  generate
    if (DELAY > 1) begin : g_addr
      // In BFLY the low bits of cnt equal cnt-DELAY.
      assign bus.tw_addr = (phase == BFLY) ? cnt_q[AW-1:0] : '0;
    end else begin : g_addr_tie
      assign bus.tw_addr = '0;
    end
  endgenerate

  sdf_delay_line #(
    .WIDTH (DW),
    .DEPTH (DELAY)
  ) u_line (
    .clk  (clk),
    .en   (bus.in_valid),
    .din  (line_din),
    .dout (line_dout)
  );

  // Complex twiddle multiply on the lower input, then the butterfly sums.
  always_comb begin
    a_re   = PW'($signed(line_dout[DW-1:bit_width]));
    a_im   = PW'($signed(line_dout[bit_width-1:0]));
    b_re   = PW'(bus.Re_in);
    b_im   = PW'(bus.Im_in);
    cos_x  = PW'(bus.cos_data);
    sin_x  = PW'(bus.sin_data);
    s_x    = bus.inverse ? -sin_x : sin_x;
    sum_re = b_re * cos_x - b_im * s_x + RND;
    sum_im = b_im * cos_x + b_re * s_x + RND;
    t_re   = sum_re >>> SH;
    t_im   = sum_im >>> SH;
    top_re = bit_width'(a_re + t_re);
    top_im = bit_width'(a_im + t_im);
    bot_re = bit_width'(a_re - t_re);
    bot_im = bit_width'(a_im - t_im);
  end

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    re_out_d    = re_out_q;
    im_out_d    = im_out_q;
    line_din    = {bus.Re_in, bus.Im_in};
    if (bus.in_valid) begin
      // Natural CW-bit wrap gives 2*DELAY-1 -> 0 without a bubble.
      cnt_d = cnt_q + 1'b1;
      if (phase == FILL) begin
        re_out_d    = line_dout[DW-1:bit_width];
        im_out_d    = line_dout[bit_width-1:0];
        out_valid_d = primed_q;
      end else begin
        re_out_d    = top_re;
        im_out_d    = top_im;
        out_valid_d = 1'b1;
        primed_d    = 1'b1;
        line_din    = {bot_re, bot_im};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      re_out_q    <= '0;
      im_out_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      re_out_q    <= re_out_d;
      im_out_q    <= im_out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Re_out    = re_out_q;
  assign bus.Im_out    = im_out_q;
  assign bus.phase     = phase;

endmodule

// File: tb/tb_radix2_dit_sdf_stage.sv
// Bench for radix2_dit_sdf_stage: one DELAY=1 and one DELAY=4 instance, each
// checked against an independent RAM-style model through an expected queue.
module tb_radix2_dit_sdf_stage;
  import fft_pkg::*;

  localparam int BW = 16;
  localparam int TW = 8;
  localparam int SH = TW - 2;

`ifdef RADIX2_DIT_ROUND_EN
  localparam logic [15:0] RND_POS = 16'h0001;
  localparam logic [15:0] RND_NEG = 16'h0000;
  localparam longint      RND_ADD = 64'sd32;
`else
  localparam logic [15:0] RND_POS = 16'h0000;
  localparam logic [15:0] RND_NEG = 16'hFFFF;
  localparam longint      RND_ADD = 64'sd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  radix2_dit_sdf_stage_if #(.bit_width(BW), .word_length_tw(TW), .DELAY(1)) b1 ();
  radix2_dit_sdf_stage_if #(.bit_width(BW), .word_length_tw(TW), .DELAY(4)) b4 ();

  radix2_dit_sdf_stage #(.bit_width(BW), .word_length_tw(TW), .DELAY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  radix2_dit_sdf_stage #(.bit_width(BW), .word_length_tw(TW), .DELAY(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp1_q[$];
  logic [31:0] exp4_q[$];
  int          m_cnt[2];
  bit          m_primed[2];
  logic [31:0] m_line[2][4];
  int          n_out1 = 0;
  int          n_out4 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dly(input int k);
    return (k != 0) ? 4 : 1;
  endfunction

  task automatic push_exp(input int k, input logic [31:0] e);
    if (k == 0) exp1_q.push_back(e);
    else        exp4_q.push_back(e);
  endtask

  // Circular-buffer model: slot index = position within the half block.
  task automatic model_step(input int k, input int re, input int im,
                            input int c, input int s, input bit inv);
    int d, slot;
    longint ar, ai, se, tr, ti;
    d = dly(k);
    if (m_cnt[k] < d) begin
      if (m_primed[k]) push_exp(k, m_line[k][m_cnt[k]]);
      m_line[k][m_cnt[k]] = {16'(re), 16'(im)};
    end else begin
      slot = m_cnt[k] - d;
      ar = longint'($signed(m_line[k][slot][31:16]));
      ai = longint'($signed(m_line[k][slot][15:0]));
      se = inv ? -longint'(s) : longint'(s);
      tr = longint'(re) * c - longint'(im) * se + RND_ADD;
      ti = longint'(im) * c + longint'(re) * se + RND_ADD;
      tr = tr >>> SH;
      ti = ti >>> SH;
      push_exp(k, {16'(ar + tr), 16'(ai + ti)});
      m_line[k][slot] = {16'(ar - tr), 16'(ai - ti)};
      m_primed[k] = 1'b1;
    end
    m_cnt[k] = (m_cnt[k] + 1) % (2 * d);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input int re, input int im,
                       input int c, input int s, input bit inv);
    int d, ea;
    string tag_a, tag_p;
    logic [31:0] got_a, got_p;
    d  = dly(k);
    ea = (m_cnt[k] >= d) ? (m_cnt[k] - d) : 0;
    if (k == 0) begin
      b1.in_valid = 1'b1; b1.Re_in = 16'(re); b1.Im_in = 16'(im);
      b1.cos_data = 8'(c); b1.sin_data = 8'(s); b1.inverse = inv;
    end else begin
      b4.in_valid = 1'b1; b4.Re_in = 16'(re); b4.Im_in = 16'(im);
      b4.cos_data = 8'(c); b4.sin_data = 8'(s); b4.inverse = inv;
    end
    #1;
    tag_a = (k == 0) ? "d1_tw_addr" : "d4_tw_addr";
    tag_p = (k == 0) ? "d1_phase" : "d4_phase";
    got_a = (k == 0) ? 32'(b1.tw_addr) : 32'(b4.tw_addr);
    got_p = (k == 0) ? 32'(b1.phase) : 32'(b4.phase);
    check(tag_a, got_a, 32'(ea));
    check(tag_p, got_p, (m_cnt[k] >= d) ? 32'd1 : 32'd0);
    model_step(k, re, im, c, s, inv);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    b4.in_valid = 1'b0;
  endtask

  task automatic idle4(input int n);
    logic [31:0] held;
    held = {b4.Re_out, b4.Im_out};
    repeat (n) @(posedge clk);
    #1;
    check("d4_gap_novalid", 32'(b4.out_valid), 32'd0);
    check("d4_gap_hold", {b4.Re_out, b4.Im_out}, held);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    check("d1_drained", 32'(exp1_q.size()), 32'd0);
    check("d4_drained", 32'(exp4_q.size()), 32'd0);
    rst_n = 1'b0;
    #2;
    check("rst_d1_valid", 32'(b1.out_valid), 32'd0);
    check("rst_d1_out", {b1.Re_out, b1.Im_out}, 32'd0);
    check("rst_d4_valid", 32'(b4.out_valid), 32'd0);
    check("rst_d4_out", {b4.Re_out, b4.Im_out}, 32'd0);
    check("rst_d4_tw_addr", 32'(b4.tw_addr), 32'd0);
    exp1_q.delete();
    exp4_q.delete();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_primed[k] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n && b1.out_valid) begin
      n_out1++;
      if (exp1_q.size() == 0) check("d1_unexpected_valid", 32'(b1.out_valid), 32'd0);
      else check("d1_out", {b1.Re_out, b1.Im_out}, exp1_q.pop_front());
    end
    if (rst_n && b4.out_valid) begin
      n_out4++;
      if (exp4_q.size() == 0) check("d4_unexpected_valid", 32'(b4.out_valid), 32'd0);
      else check("d4_out", {b4.Re_out, b4.Im_out}, exp4_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int imp[12];
    b1.in_valid = 1'b0; b1.Re_in = '0; b1.Im_in = '0; b1.inverse = 1'b0;
    b1.cos_data = '0;   b1.sin_data = '0;
    b4.in_valid = 1'b0; b4.Re_in = '0; b4.Im_in = '0; b4.inverse = 1'b0;
    b4.cos_data = '0;   b4.sin_data = '0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_primed[k] = 1'b0;
    end
    #3;
    check("init_d1_valid", 32'(b1.out_valid), 32'd0);
    check("init_d1_out", {b1.Re_out, b1.Im_out}, 32'd0);
    check("init_d4_valid", 32'(b4.out_valid), 32'd0);
    check("init_d4_tw_addr", 32'(b4.tw_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // DELAY=1, real unity twiddle
    drive(0, 100, 0, 64, 0, 1'b0);
    check("d1_first_novalid", 32'(b1.out_valid), 32'd0);
    drive(0, 50, 0, 64, 0, 1'b0);
    check("d1_sum", {b1.Re_out, b1.Im_out}, {16'd150, 16'd0});
    drive(0, 0, 0, 64, 0, 1'b0);
    check("d1_diff", {b1.Re_out, b1.Im_out}, {16'd50, 16'd0});

    // DELAY=1, W = j, forward then conjugated
    do_reset();
    drive(0, 0, 0, 0, 64, 1'b0);
    drive(0, 10, 0, 0, 64, 1'b0);
    check("d1_j_fwd_sum", {b1.Re_out, b1.Im_out}, {16'd0, 16'd10});
    drive(0, 0, 0, 0, 64, 1'b0);
    check("d1_j_fwd_diff", {b1.Re_out, b1.Im_out}, {16'd0, 16'hFFF6});
    do_reset();
    drive(0, 0, 0, 0, 64, 1'b1);
    drive(0, 10, 0, 0, 64, 1'b1);
    check("d1_j_inv_sum", {b1.Re_out, b1.Im_out}, {16'd0, 16'hFFF6});
    drive(0, 0, 0, 0, 64, 1'b1);
    check("d1_j_inv_diff", {b1.Re_out, b1.Im_out}, {16'd0, 16'd10});

    // Overflow wraps
    do_reset();
    drive(0, 32767, 0, 64, 0, 1'b0);
    drive(0, 1, 0, 64, 0, 1'b0);
    check("d1_wrap", {b1.Re_out, b1.Im_out}, {16'h8000, 16'd0});
    drive(0, 0, 0, 64, 0, 1'b0);
    check("d1_wrap_stored", {b1.Re_out, b1.Im_out}, {16'h7FFE, 16'd0});

    // Half-unity twiddle: truncation vs rounding
    do_reset();
    drive(0, 0, 0, 32, 0, 1'b0);
    drive(0, 1, 0, 32, 0, 1'b0);
    check("d1_round_pos", {b1.Re_out, b1.Im_out}, {RND_POS, 16'd0});
    drive(0, 0, 0, 32, 0, 1'b0);
    drive(0, -1, 0, 32, 0, 1'b0);
    check("d1_round_neg", {b1.Re_out, b1.Im_out}, {RND_NEG, 16'd0});
    drive(0, 0, 0, 32, 0, 1'b0);

    // DELAY=1 random data, twiddles, inverse
    for (int i = 0; i < 40; i++) begin
      drive(0, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            1'($urandom_range(0, 1)));
    end
    drive(0, 0, 0, 64, 0, 1'b0);

    // DELAY=4 impulse, gap-free
    for (int i = 0; i < 12; i++) imp[i] = (i == 0) ? 1000 : 0;
    do_reset();
    base = n_out4;
    for (int i = 0; i < 12; i++) drive(1, imp[i], 0, 64, 0, 1'b0);
    @(negedge clk); #1;
    check("d4_impulse_count", 32'(n_out4 - base), 32'd8);

    // Same stream with random gaps
    do_reset();
    base = n_out4;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) idle4(1);
      drive(1, imp[i], 0, 64, 0, 1'b0);
    end
    @(negedge clk); #1;
    check("d4_gap_count", 32'(n_out4 - base), 32'd8);

    // DELAY=4 random traffic with gaps and per-sample inverse
    do_reset();
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) idle4(int'($urandom_range(1, 3)));
      drive(1, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 64, 0, 1'b0);

    // Reset in the middle of a butterfly half
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, 100 * (i + 1), -50 * i, 64, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 7, 64, 0, 1'b0);
      check("d4_post_reset_novalid", 32'(b4.out_valid), 32'd0);
    end

    @(negedge clk); #1;
    check("d1_final_drained", 32'(exp1_q.size()), 32'd0);
    check("d4_final_drained", 32'(exp4_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
